// File: rtl/fifo_stream_drain.sv
// Read-side FIFO drain: absorbs the FIFO's one-cycle read latency in a two-entry skid buffer
// and presents a valid/ready stream with frame markers. Optional parity: define FIFO_DRAIN_PARITY_EN.
module fifo_stream_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAME_LEN  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  frame_cnt
`ifdef FIFO_DRAIN_PARITY_EN
   ,
   output logic                  m_par
`endif
);

   localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

   logic [1:0]            count_reg, count_next;
   logic                  head_reg, head_next;
   logic                  inflight_reg;
   logic [BEAT_W-1:0]     beat_reg, beat_next;
   logic [CNT_WIDTH-1:0]  frame_cnt_reg, frame_cnt_next;

   logic                  pop;
   logic                  tail;
   logic [2:0]            occupancy;
   logic [DATA_WIDTH-1:0] head_data;

   assign pop  = m_valid & m_ready;
   assign tail = head_reg ^ count_reg[0];

   // Slots committed after this edge; a pop this cycle frees one before the next word lands.
   assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   // Held low in reset so nothing is popped from a FIFO that is being cleared alongside us.
   assign fifo_rd_en = rst_n & ~fifo_empty & (occupancy < 3'd2);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] data_reg;
`ifdef FIFO_DRAIN_PARITY_EN
         logic                  par_reg;
`endif
         always_ff @(posedge rd_clk) begin
            if (!rst_n) begin
               data_reg <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
               par_reg  <= 1'b0;
`endif
            end else if (inflight_reg && (tail == 1'(gi))) begin
               data_reg <= fifo_dout;
`ifdef FIFO_DRAIN_PARITY_EN
               par_reg  <= ^fifo_dout;
`endif
            end
         end
      end
   endgenerate

   assign head_data = head_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

   assign m_valid   = (count_reg != 2'd0);
   assign m_data    = m_valid ? head_data : '0;
   assign m_last    = m_valid && (beat_reg == LAST_BEAT);
   assign frame_cnt = frame_cnt_reg;

`ifdef FIFO_DRAIN_PARITY_EN
   assign m_par = m_valid & (head_reg ? g_entry[1].par_reg : g_entry[0].par_reg);
`endif

   always_comb begin
      count_next     = count_reg;
      head_next      = head_reg;
      beat_next      = beat_reg;
      frame_cnt_next = frame_cnt_reg;

      unique case ({inflight_reg, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase

      if (pop) begin
         head_next = ~head_reg;
         if (beat_reg == LAST_BEAT) begin
            beat_next      = '0;
            frame_cnt_next = frame_cnt_reg + CNT_WIDTH'(1);
         end else begin
            beat_next = beat_reg + BEAT_W'(1);
         end
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         count_reg     <= '0;
         head_reg      <= 1'b0;
         inflight_reg  <= 1'b0;
         beat_reg      <= '0;
         frame_cnt_reg <= '0;
      end else begin
         assert (!(inflight_reg && (count_reg == 2'd2)));
         count_reg     <= count_next;
         head_reg      <= head_next;
         inflight_reg  <= fifo_rd_en;
         beat_reg      <= beat_next;
         frame_cnt_reg <= frame_cnt_next;
      end
   end

endmodule
